// File: rtl/ram_loader.sv
// ram_loader: loads a framed byte stream (length, data, checksum) into the
// program RAM and holds the CPU in clear until a load has verified.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | after reset, waiting for start; CPU not held
// S_LEN   | waiting for the length byte
// S_DATA  | receiving data bytes, one RAM write per accepted byte
// S_CHK   | waiting for the checksum byte
// S_DONE  | last load verified; CPU released
// S_ERROR | last load failed (checksum or timeout); CPU kept in clear
module ram_loader #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              cpu_clr_n,
  output logic              done,
  output logic              err
);

  localparam int WORDS = 2 ** ADDR_W;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]  FULL_LEN = (ADDR_W + 1)'(WORDS);
  // Idle count at which one more idle cycle would reach TIMEOUT.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   len, len_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [DATA_W-1:0] sum, sum_nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              clr_n_nxt;
  logic              done_nxt;
  logic              err_nxt;
  logic              xfer;
  logic              last_word;
  logic [ADDR_W:0]   len_raw;
  logic [ADDR_W:0]   len_dec;

  // Stream is open only while a frame is being received.
  assign byte_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign xfer       = byte_valid && byte_ready;

  // Length field: zero or anything beyond the RAM size means a full image.
  assign len_raw = byte_in[ADDR_W:0];
  assign len_dec = ((len_raw == '0) || (len_raw > FULL_LEN)) ? FULL_LEN : len_raw;

  // The index stops at the final word instead of wrapping.
  assign last_word = ({1'b0, idx} == (len - 1'b1));

  // State register and all registered outputs/counters.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_IDLE;
      len       <= '0;
      idx       <= '0;
      sum       <= '0;
      tmr       <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      cpu_clr_n <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      idx       <= idx_nxt;
      sum       <= sum_nxt;
      tmr       <= tmr_nxt;
      ram_we    <= we_nxt;
      ram_addr  <= addr_nxt;
      ram_data  <= data_nxt;
      cpu_clr_n <= clr_n_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    idx_nxt   = idx;
    sum_nxt   = sum;
    tmr_nxt   = tmr;
    we_nxt    = 1'b0;
    addr_nxt  = ram_addr;
    data_nxt  = ram_data;
    clr_n_nxt = cpu_clr_n;
    done_nxt  = done;
    err_nxt   = err;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_nxt = S_LEN;
          clr_n_nxt = 1'b0;
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
          idx_nxt   = '0;
          sum_nxt   = '0;
          tmr_nxt   = '0;
        end
      end

      S_LEN: begin
        if (xfer) begin
          len_nxt   = len_dec;
          tmr_nxt   = '0;
          state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        if (xfer) begin
          we_nxt   = 1'b1;
          addr_nxt = idx;
          data_nxt = byte_in;
          sum_nxt  = sum + byte_in;
          tmr_nxt  = '0;
          if (last_word) begin
            state_nxt = S_CHK;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end

      S_CHK: begin
        if (xfer) begin
          tmr_nxt = '0;
          if (byte_in == sum) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            clr_n_nxt = 1'b1;
          end else begin
            state_nxt = S_ERROR;
            err_nxt   = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Inter-byte timeout; an accepted byte always wins over expiry.
    if (byte_ready && !xfer) begin
      if (tmr == TMR_LAST) begin
        state_nxt = S_ERROR;
        err_nxt   = 1'b1;
      end else begin
        tmr_nxt = tmr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader with a short timeout.
module tb_ram_loader;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       cpu_clr_n;
  logic       done;
  logic       err;

  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] img [16];

  ram_loader #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .clr(clr), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data(ram_data), .cpu_clr_n(cpu_clr_n),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!clr && ram_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {28'd0, ram_addr}, 32'hffff_ffff);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", {28'd0, ram_addr}, {28'd0, w.a});
        chk("wr_data", {24'd0, ram_data}, {24'd0, w.d});
        chk("wr_cycle", cyc, w.cyc);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer a byte until accepted; a data byte queues its expected write.
  task automatic send(input logic [7:0] b, input logic is_data, input logic [3:0] a);
    int n;
    wr_t w;
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("send_timeout", 0, 1);
    end else if (is_data) begin
      w.cyc = cyc + 1;
      w.a   = a;
      w.d   = b;
      exp_q.push_back(w);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic poke_start);
    byte_valid = 1'b0;
    start = poke_start;
    repeat (n) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] lb, input int n, input int gap, input logic [7:0] ck);
    pulse_start();
    chk("start_clr_n", {31'd0, cpu_clr_n}, 0);
    chk("start_ready", {31'd0, byte_ready}, 1);
    send(lb, 1'b0, 4'd0);
    for (int i = 0; i < n; i++) begin
      send(img[i], 1'b1, 4'(i));
      if (gap > 0) idle(gap, (i == 1));
    end
    send(ck, 1'b0, 4'd0);
  endtask

  task automatic expect_end(input string tag, input logic e_done, input logic e_err, input logic e_clr_n);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
    chk({tag, "_clr_n"}, {31'd0, cpu_clr_n}, {31'd0, e_clr_n});
    chk({tag, "_ready"}, {31'd0, byte_ready}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    clr = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, byte_ready}, 0);
    chk("rst_we", {31'd0, ram_we}, 0);
    chk("rst_addr", {28'd0, ram_addr}, 0);
    chk("rst_data", {24'd0, ram_data}, 0);
    chk("rst_clr_n", {31'd0, cpu_clr_n}, 1);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    clr = 1'b0;
    @(negedge clk);

    // Nominal back-to-back load.
    img[0] = 8'h1A; img[1] = 8'h2B; img[2] = 8'h3C;
    do_load(8'h03, 3, 0, 8'h81);
    expect_end("nominal", 1, 0, 1);

    // Full RAM, checksum wraps to zero.
    for (int i = 0; i < 16; i++) img[i] = 8'h10;
    do_load(8'h00, 16, 0, 8'h00);
    expect_end("full", 1, 0, 1);

    // Length field above RAM size means a full image.
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      img[i] = 8'(i * 7 + 3);
      s = s + img[i];
    end
    do_load(8'h31, 16, 0, s);
    expect_end("overlen", 1, 0, 1);

    // Checksum mismatch.
    img[0] = 8'h05; img[1] = 8'h06;
    do_load(8'h02, 2, 0, 8'h0C);
    expect_end("badchk", 0, 1, 0);

    // Timeout: stall TMO cycles after the first data byte.
    img[0] = 8'h11;
    pulse_start();
    send(8'h03, 1'b0, 4'd0);
    send(img[0], 1'b1, 4'd0);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_not_yet", {31'd0, err}, 0);
    @(negedge clk);
    expect_end("tmo", 0, 1, 0);

    // Transfer exactly on the expiry cycle is accepted.
    img[0] = 8'h21; img[1] = 8'h22; img[2] = 8'h23;
    pulse_start();
    send(8'h03, 1'b0, 4'd0);
    send(img[0], 1'b1, 4'd0);
    repeat (TMO - 1) @(negedge clk);
    send(img[1], 1'b1, 4'd1);
    chk("tmo_edge_err", {31'd0, err}, 0);
    send(img[2], 1'b1, 4'd2);
    send(8'h66, 1'b0, 4'd0);
    expect_end("tmo_edge", 1, 0, 1);

    // Gapped valid with a start pulse inside DATA.
    img[0] = 8'h1A; img[1] = 8'h2B; img[2] = 8'h3C;
    do_load(8'h03, 3, 1, 8'h81);
    expect_end("gapped", 1, 0, 1);

    // Async reset between edges in DATA.
    img[0] = 8'h44; img[1] = 8'h55;
    pulse_start();
    send(8'h04, 1'b0, 4'd0);
    send(img[0], 1'b1, 4'd0);
    send(img[1], 1'b1, 4'd1);
    #2 clr = 1'b1;
    #1;
    chk("arst_ready", {31'd0, byte_ready}, 0);
    chk("arst_we", {31'd0, ram_we}, 0);
    chk("arst_addr", {28'd0, ram_addr}, 0);
    chk("arst_data", {24'd0, ram_data}, 0);
    chk("arst_clr_n", {31'd0, cpu_clr_n}, 1);
    chk("arst_err", {31'd0, err}, 0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Clean reload after reset.
    img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
    do_load(8'h04, 4, 0, 8'h0A);
    expect_end("reload", 1, 0, 1);

    repeat (3) @(negedge clk);
    chk("writes_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Writes a program image into the 16x8 program RAM before the CPU runs.
- Accepts a framed byte stream over a valid/ready handshake: length byte, data bytes, checksum byte.
- Generates the RAM write strobe, address and data.
- Holds the CPU in clear through `cpu_clr_n` for the whole load, and releases it only after a load with a good checksum.

Parameters:
- ADDR_W, 4, RAM address width; the RAM holds 2**ADDR_W words.
- DATA_W, 8, RAM word and stream byte width.
- TIMEOUT, 255, maximum idle cycles allowed between accepted bytes during a load.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_in  input  DATA_W  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader will accept a byte this cycle.
- ram_we  output  1  RAM write strobe, one cycle per data byte.
- ram_addr  output  ADDR_W  RAM write address.
- ram_data  output  DATA_W  RAM write data.
- cpu_clr_n  output  1  active-low clear to the controller/sequencer and PC.
- done  output  1  last load finished with a good checksum.
- err  output  1  last load failed (checksum or timeout).

Behaviour:
- Reset (async, clr=1): state=IDLE, byte_ready=0, ram_we=0, ram_addr=0, ram_data=0, cpu_clr_n=1, done=0, err=0. Internal length, index, checksum and timer are all cleared.
- Reset mid-load: the load is abandoned immediately. Words already written stay in RAM.
- A byte transfer occurs on a rising edge where byte_valid=1 and byte_ready=1.
- byte_ready is asserted only in LEN, DATA and CHK.
- Start, from IDLE, DONE or ERROR with start=1:
  - next state is LEN;
  - cpu_clr_n=0, done=0, err=0;
  - index, checksum and timer cleared.
- start is ignored in LEN, DATA and CHK.
- LEN state:
  - The accepted byte sets length N = byte_in[ADDR_W:0] interpreted as follows: value 0, or any value above 2**ADDR_W, means 2**ADDR_W words.
  - Next state is DATA.
- DATA state, on each accepted byte:
  - next cycle: ram_we=1, ram_addr=index, ram_data=byte_in (write latency exactly 1 cycle after the transfer);
  - checksum += byte_in, modulo 2**DATA_W;
  - index increments;
  - after the Nth byte, next state is CHK.
- ram_we is low in every other cycle.
- Back-to-back transfers produce back-to-back write pulses with consecutive addresses.
- index never wraps inside a load. Its maximum is 2**ADDR_W-1.
- CHK state, on the accepted byte:
  - byte_in == checksum: next state DONE; done=1, cpu_clr_n=1.
  - otherwise: next state ERROR; err=1, cpu_clr_n stays 0.
- Timeout:
  - In LEN, DATA and CHK the timer counts cycles with no transfer, and clears on every transfer.
  - When the timer reaches TIMEOUT, next state is ERROR with err=1.
  - A transfer in the same cycle the timer would reach TIMEOUT takes priority: it is accepted and the timer clears.
- DONE and ERROR: byte_ready=0. Both hold until start or reset.
- Writes are never rolled back. On ERROR the RAM contents are partial or unchecked, which is why the CPU stays held in clear.
- ram_addr and ram_data hold their last value when ram_we=0.

Test Plan:
- Nominal load: start, then bytes 0x03,0x1A,0x2B,0x3C,0x81, each valid for 1 cycle → writes (0,0x1A),(1,0x2B),(2,0x3C), each 1 cycle after its transfer; checksum 0x81 accepted; done=1, cpu_clr_n=1, err=0.
- Full RAM with wrap: length 0x00, then 16 bytes of 0x10, then checksum 0x00 → 16 writes at addresses 0..15; checksum sum wraps to 0x00 and matches; done=1.
- Checksum error: length 0x02, data 0x05,0x06, checksum 0x0C → 2 writes occur; err=1, done=0, cpu_clr_n stays 0.
- Timeout with TIMEOUT=8: stall 8 cycles after the first data byte → err=1, byte_ready=0. A second run with a transfer exactly on cycle 8 → no error.
- Gapped valid: same data as the nominal load but byte_valid toggled every other cycle → identical writes and done=1. Also: start pulsed during DATA is ignored.
- Async reset: assert clr mid-DATA between clock edges → outputs take reset values immediately without a clock edge. A new start then reloads cleanly.
